// File: rtl/multi_blinky.sv
// rtl/multi_blinky.sv - N-channel LED blinker sharing one free-running tick prescaler
module multi_blinky #(
  parameter int clk_freq_hz = 12_000_000,
  parameter int tick_hz     = 1_000,
  parameter int n_ch        = 4,
  parameter int half_w      = 16,
  parameter int half_rst    = 500,
  localparam int ch_w       = (n_ch > 1) ? $clog2(n_ch) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              cfg_we,
  input  logic [ch_w-1:0]   cfg_ch,
  input  logic [1:0]        cfg_mode,
  input  logic [half_w-1:0] cfg_half,
  output logic              tick,
  output logic [n_ch-1:0]   busy,
  output logic [n_ch-1:0]   q
);

  localparam int div  = clk_freq_hz / tick_hz;
  localparam int pc_w = (div > 1) ? $clog2(div) : 1;
  localparam logic [pc_w-1:0] pc_last = pc_w'(div - 1);

  localparam logic [1:0] mode_off   = 2'd0;
  localparam logic [1:0] mode_on    = 2'd1;
  localparam logic [1:0] mode_blink = 2'd2;
  localparam logic [1:0] mode_shot  = 2'd3;

  if (div < 1) begin : g_div_check
    $error("multi_blinky: clk_freq_hz / tick_hz must be at least 1");
  end

  logic [pc_w-1:0] pcnt;

  // Free-running: config writes never disturb the tick phase.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      pcnt <= '0;
      tick <= 1'b0;
    end else begin
      tick <= (pcnt == pc_last);
      pcnt <= (pcnt == pc_last) ? '0 : pcnt + pc_w'(1);
    end
  end

  for (genvar i = 0; i < n_ch; i++) begin : g_ch
    logic [1:0]        mode;
    logic [half_w-1:0] half;
    logic [half_w-1:0] cnt;
    logic              q_r;
    logic              busy_r;
    logic              hit;

    assign hit     = cfg_we && (cfg_ch == ch_w'(i));
    assign q[i]    = q_r;
    assign busy[i] = busy_r;

    // A write on a tick edge swallows that tick for this channel only.
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        mode   <= mode_off;
        half   <= half_w'(half_rst);
        cnt    <= '0;
        q_r    <= 1'b0;
        busy_r <= 1'b0;
      end else if (hit) begin
        mode   <= cfg_mode;
        half   <= (cfg_half == '0) ? half_w'(1) : cfg_half;
        cnt    <= '0;
        q_r    <= (cfg_mode != mode_off);
        busy_r <= (cfg_mode == mode_shot);
      end else if (tick) begin
        case (mode)
          mode_on: begin
            q_r <= 1'b1;
            cnt <= '0;
          end
          mode_blink: begin
            if (cnt == half - half_w'(1)) begin
              cnt <= '0;
              q_r <= ~q_r;
            end else begin
              cnt <= cnt + half_w'(1);
            end
          end
          mode_shot: begin
            if (cnt == half - half_w'(1)) begin
              cnt    <= '0;
              q_r    <= 1'b0;
              busy_r <= 1'b0;
              mode   <= mode_off;
            end else begin
              cnt <= cnt + half_w'(1);
            end
          end
          default: begin
            q_r <= 1'b0;
            cnt <= '0;
          end
        endcase
      end
    end
  end

endmodule

// File: tb/tb_multi_blinky.sv
// tb/tb_multi_blinky.sv - self-checking bench for multi_blinky against a tick-count reference model
module tb_multi_blinky;
  localparam int DIV = 10;
  localparam int NCH = 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic cfg_we = 1'b0;
  logic [1:0] cfg_ch = 2'd0;
  logic [1:0] cfg_mode = 2'd0;
  logic [7:0] cfg_half = 8'd0;
  logic tick;
  logic [NCH-1:0] busy;
  logic [NCH-1:0] q;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  multi_blinky #(
    .clk_freq_hz(1000), .tick_hz(100), .n_ch(NCH), .half_w(8), .half_rst(50)
  ) dut (
    .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_ch(cfg_ch), .cfg_mode(cfg_mode),
    .cfg_half(cfg_half), .tick(tick), .busy(busy), .q(q)
  );

  // Reference: per channel, the number of ticks seen since its last write.
  int   m_edges = 0;
  logic m_tick = 1'b0;
  int   m_mode[NCH] = '{default: 0};
  int   m_half[NCH] = '{default: 50};
  int   m_nt[NCH]   = '{default: 0};

  always @(posedge clk) begin
    if (!rst_n) begin
      m_edges <= 0;
      m_tick  <= 1'b0;
      for (int c = 0; c < NCH; c++) begin
        m_mode[c] <= 0;
        m_half[c] <= 50;
        m_nt[c]   <= 0;
      end
    end else begin
      m_edges <= m_edges + 1;
      m_tick  <= ((m_edges + 1) % DIV == 0);
      for (int c = 0; c < NCH; c++) begin
        if (cfg_we && cfg_ch == c) begin
          m_mode[c] <= int'(cfg_mode);
          m_half[c] <= (cfg_half == 0) ? 1 : int'(cfg_half);
          m_nt[c]   <= 0;
        end else if (m_tick && m_nt[c] < 100000) begin
          m_nt[c] <= m_nt[c] + 1;
        end
      end
    end
  end

  function automatic logic [NCH-1:0] mq();
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) begin
      case (m_mode[c])
        0:       v[c] = 1'b0;
        1:       v[c] = 1'b1;
        2:       v[c] = ((m_nt[c] / m_half[c]) % 2) == 0;
        default: v[c] = m_nt[c] < m_half[c];
      endcase
    end
    return v;
  endfunction

  function automatic logic [NCH-1:0] mb();
    logic [NCH-1:0] v;
    v = '0;
    for (int c = 0; c < NCH; c++) v[c] = (m_mode[c] == 3) && (m_nt[c] < m_half[c]);
    return v;
  endfunction

  task automatic do_write(input int ch, input int mode, input int half);
    cfg_we   = 1'b1;
    cfg_ch   = ch[1:0];
    cfg_mode = mode[1:0];
    cfg_half = half[7:0];
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (q !== 3'b000 || busy !== 3'b000 || tick !== 1'b0)
      $display("FAIL reset_state: q=%b busy=%b tick=%b, expected 000 000 0", q, busy, tick);
    if (q !== 3'b000 || busy !== 3'b000 || tick !== 1'b0) errors++;
    rst_n = 1'b1;
    for (int t = 1; t <= 35; t++) begin
      @(negedge clk);
      checks++;
      if (tick !== (t % 10 == 0) || q !== mq() || busy !== mb()) begin
        errors++;
        $display("FAIL reset_tick_phase t=%0d: tick=%b q=%b busy=%b, expected tick=%b q=%b busy=%b",
                 t, tick, q, busy, (t % 10 == 0), mq(), mb());
      end
    end
  endtask

  task automatic test_on_off();
    do_write(1, 1, 0);
    checks++;
    if (q[1] !== 1'b1) begin errors++; $display("FAIL on_latency: q[1]=%b, expected 1", q[1]); end
    for (int t = 0; t < 500; t++) begin
      @(negedge clk);
      checks++;
      if (q[1] !== 1'b1 || q !== mq() || busy !== mb() || tick !== m_tick) begin
        errors++;
        $display("FAIL on_hold t=%0d: q=%b busy=%b, expected q=%b busy=%b", t, q, busy, mq(), mb());
      end
    end
    do_write(1, 0, 0);
    checks++;
    if (q[1] !== 1'b0) begin errors++; $display("FAIL off_latency: q[1]=%b, expected 0", q[1]); end
  endtask

  task automatic test_blink();
    int t;
    logic prev;
    do_write(0, 2, 3);
    checks++;
    if (q[0] !== 1'b1) begin errors++; $display("FAIL blink_start: q[0]=%b, expected 1", q[0]); end
    t = 0;
    while (q[0] === 1'b1 && t < 40) begin
      @(negedge clk); t++;
      checks++;
      if (q !== mq() || tick !== m_tick) begin
        errors++; $display("FAIL blink_model: q=%b tick=%b, expected q=%b tick=%b", q, tick, mq(), m_tick);
      end
    end
    checks++;
    if (t < 21 || t > 30) begin errors++; $display("FAIL blink_first: interval=%0d, expected 21..30", t); end
    for (int k = 0; k < 10; k++) begin
      prev = q[0]; t = 0;
      do begin @(negedge clk); t++; end while (q[0] === prev && t < 40);
      checks++;
      if (t !== 30) begin errors++; $display("FAIL blink_period k=%0d: interval=%0d, expected 30", k, t); end
    end
    do_write(0, 2, 0);
    prev = q[0]; t = 0;
    do begin @(negedge clk); t++; end while (q[0] === prev && t < 15);
    for (int k = 0; k < 4; k++) begin
      prev = q[0]; t = 0;
      do begin @(negedge clk); t++; end while (q[0] === prev && t < 15);
      checks++;
      if (t !== 10) begin errors++; $display("FAIL blink_half0 k=%0d: interval=%0d, expected 10", k, t); end
    end
    do_write(0, 0, 0);
  endtask

  task automatic test_oneshot();
    int t;
    for (int pass = 0; pass < 2; pass++) begin
      do_write(2, 3, 5);
      if (pass == 1) begin
        repeat (19) @(negedge clk);
        do_write(2, 3, 5);
      end
      checks++;
      if (q[2] !== 1'b1 || busy[2] !== 1'b1) begin
        errors++; $display("FAIL oneshot_start pass=%0d: q[2]=%b busy[2]=%b, expected 1 1", pass, q[2], busy[2]);
      end
      t = 0;
      while (q[2] === 1'b1 && t < 60) begin
        @(negedge clk); t++;
        checks++;
        if (busy[2] !== q[2] || q !== mq() || busy !== mb()) begin
          errors++; $display("FAIL oneshot_together: q=%b busy=%b, expected q=%b busy=%b", q, busy, mq(), mb());
        end
      end
      checks++;
      if (t < 41 || t > 50) begin errors++; $display("FAIL oneshot_window pass=%0d: fall=%0d, expected 41..50", pass, t); end
    end
    for (int k = 0; k < 300; k++) begin
      @(negedge clk);
      checks++;
      if (q[2] !== 1'b0 || busy[2] !== 1'b0) begin
        errors++; $display("FAIL oneshot_hold k=%0d: q[2]=%b busy[2]=%b, expected 0 0", k, q[2], busy[2]);
      end
    end
  endtask

  task automatic test_collision();
    int t;
    logic [NCH-1:0] snap;
    do_write(1, 2, 4);
    repeat ($urandom_range(0, 30)) @(negedge clk);
    do_write(0, 2, 1);
    do_write(2, 2, 1);
    t = 0;
    while (tick !== 1'b1 && t < 20) begin @(negedge clk); t++; end
    checks++;
    if (tick !== 1'b1) begin errors++; $display("FAIL collision_tick_wait: tick=%b, expected 1", tick); end
    snap = q;
    do_write(1, 2, 4);
    checks++;
    if (q[1] !== 1'b1 || q[0] !== ~snap[0] || q[2] !== ~snap[2]) begin
      errors++; $display("FAIL collision_edge: q=%b, expected %b", q, {~snap[2], 1'b1, ~snap[0]});
    end
    t = 0;
    while (q[1] === 1'b1 && t < 60) begin
      @(negedge clk); t++;
      checks++;
      if (q !== mq()) begin errors++; $display("FAIL collision_model: q=%b, expected %b", q, mq()); end
    end
    checks++;
    if (t !== 40) begin errors++; $display("FAIL collision_restart: interval=%0d, expected 40", t); end
  endtask

  task automatic test_out_of_range();
    do_write(0, 0, 0);
    do_write(1, 1, 0);
    do_write(2, 1, 0);
    do_write(3, 0, 0);
    for (int k = 0; k < 30; k++) begin
      if (k == 15) do_write(3, 3, 5);
      else @(negedge clk);
      checks++;
      if (q !== 3'b110 || busy !== 3'b000 || q !== mq()) begin
        errors++; $display("FAIL out_of_range k=%0d: q=%b busy=%b, expected q=110 busy=000", k, q, busy);
      end
    end
  endtask

  task automatic test_random();
    for (int n = 0; n < 25; n++) begin
      do_write($urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 6));
      repeat ($urandom_range(1, 80)) begin
        @(negedge clk);
        checks++;
        if (q !== mq() || busy !== mb() || tick !== m_tick) begin
          errors++;
          $display("FAIL random n=%0d: q=%b busy=%b tick=%b, expected q=%b busy=%b tick=%b",
                   n, q, busy, tick, mq(), mb(), m_tick);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    do_write(0, 2, 3);
    do_write(2, 3, 20);
    repeat (15) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checks++;
    if (q !== 3'b000 || busy !== 3'b000 || tick !== 1'b0) begin
      errors++; $display("FAIL reset_mid: q=%b busy=%b tick=%b, expected 000 000 0", q, busy, tick);
    end
    rst_n = 1'b1;
    for (int t = 1; t <= 25; t++) begin
      @(negedge clk);
      checks++;
      if (tick !== (t % 10 == 0) || q !== 3'b000 || busy !== 3'b000) begin
        errors++; $display("FAIL reset_mid_phase t=%0d: tick=%b q=%b busy=%b, expected tick=%b q=000 busy=000",
                           t, tick, q, busy, (t % 10 == 0));
      end
    end
  endtask

  initial begin
    test_reset();
    test_on_off();
    test_blink();
    test_oneshot();
    test_collision();
    test_out_of_range();
    test_random();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
